// File: rtl/uart_rx_keypad_if.sv
// Signal bundle between the host-side UART line / board display logic and the keypad receiver.
// state_dbg mirrors the receiver FSM encoding so checkers can follow frame progress.
interface uart_rx_keypad_if;
    logic       rx;
    logic [3:0] key_code;
    logic       key_valid;
    logic       char_err;
    logic       frame_err;
    logic       rx_led;
    logic       err_led;
    logic [2:0] state_dbg;

    // Handshake: rx is a free-running asynchronous line; key_valid, char_err and
    // frame_err are single-cycle pulses with no ready, at most one high per cycle,
    // and key_code is only meaningful (and held) from a key_valid pulse onwards.
    modport master (
        output rx,
        input  key_code, key_valid, char_err, frame_err, rx_led, err_led, state_dbg
    );

    modport slave (
        input  rx,
        output key_code, key_valid, char_err, frame_err, rx_led, err_led, state_dbg
    );
endinterface

// File: rtl/uart_rx_keypad.sv
// 8N1 UART receiver that maps ASCII keypad characters (0-9, A-D/a-d, '*', '#')
// back to 4-bit keypad codes, with frame/character error pulses and LEDs.
module uart_rx_keypad #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_keypad_if.slave   bus_io
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          rx_s_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          char_err_q;
    logic          frame_err_q;
    logic          rx_led_q;
    logic          err_led_q;
    logic [4:0]    dec_w;

    // Returns {hit, code}; hit is low for bytes outside the keypad character set.
    function automatic logic [4:0] decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'b0;
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, b[3:0]};
        else if ((b >= 8'h41 && b <= 8'h44) || (b >= 8'h61 && b <= 8'h64))
            r = {1'b1, b[3:0] + 4'd9};
        else if (b == 8'h2A)
            r = {1'b1, 4'hE};
        else if (b == 8'h23)
            r = {1'b1, 4'hF};
        return r;
    endfunction

    assign dec_w = decode(shift_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= bus_io.rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            char_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_led_q    <= 1'b0;
            err_led_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            char_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= 3'd0;
                    if (!rx_s_q) begin
                        state_q  <= START;
                        rx_led_q <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q  <= IDLE;
                            rx_led_q <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s_q) begin
                            // Returning at the stop-bit midpoint leaves half a bit to catch a back-to-back start edge.
                            state_q  <= IDLE;
                            rx_led_q <= 1'b0;
                            if (dec_w[4]) begin
                                key_code_q  <= dec_w[3:0];
                                key_valid_q <= 1'b1;
                            end else begin
                                char_err_q <= 1'b1;
                                err_led_q  <= 1'b1;
                            end
                        end else begin
                            state_q     <= BREAK;
                            frame_err_q <= 1'b1;
                            err_led_q   <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q  <= IDLE;
                        rx_led_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rx_led_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.key_code  = key_code_q;
    assign bus_io.key_valid = key_valid_q;
    assign bus_io.char_err  = char_err_q;
    assign bus_io.frame_err = frame_err_q;
    assign bus_io.rx_led    = rx_led_q;
    assign bus_io.err_led   = err_led_q;
    assign bus_io.state_dbg = state_q;
endmodule

// File: tb/tb_uart_rx_keypad.sv
// Directed bench for uart_rx_keypad at 10 clocks per bit: decode, back-to-back frames,
// character/frame errors, line break, start glitch and mid-frame reset.
module tb_uart_rx_keypad;
    localparam int CPB = 10;

    logic clk;
    logic rst;
    uart_rx_keypad_if bus ();

    uart_rx_keypad #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int kv_n  = 0;
    int ce_n  = 0;
    int fe_n  = 0;
    int multi_n = 0;
    int kv_cyc  = 0;
    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.key_valid) begin
                kv_n++;
                kv_cyc = cyc;
                got_q.push_back(bus.key_code);
            end
            if (bus.char_err) ce_n++;
            if (bus.frame_err) fe_n++;
            if ((32'(bus.key_valid) + 32'(bus.char_err) + 32'(bus.frame_err)) > 1) multi_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        wait_clks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop);
    endtask

    task automatic check_keys(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_code"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int t0;
        int kv0, ce0, fe0;
        int led_hi;

        rst    = 1'b1;
        bus.rx = 1'b1;
        wait_clks(4);
        check("rst_key_code", 32'(bus.key_code), 32'h0);
        check("rst_key_valid", 32'(bus.key_valid), 32'h0);
        check("rst_rx_led", 32'(bus.rx_led), 32'h0);
        check("rst_err_led", 32'(bus.err_led), 32'h0);
        check("rst_state", 32'(bus.state_dbg), 32'h0);
        rst = 1'b0;
        wait_clks(5);

        // '7' with latency window
        t0 = cyc;
        exp_q.push_back(4'h7);
        send_frame(8'h37, 1'b1);
        wait_clks(10);
        check("seven_kv_cycles", 32'(kv_n), 32'd1);
        check("seven_latency_ok", 32'((kv_cyc - t0) >= 90 && (kv_cyc - t0) <= 105), 32'd1);
        check("seven_key_code", 32'(bus.key_code), 32'h7);
        check("seven_char_err", 32'(ce_n), 32'd0);
        check("seven_frame_err", 32'(fe_n), 32'd0);
        check_keys("seven");

        // back-to-back '*', '#', 'b'
        exp_q.push_back(4'hE);
        exp_q.push_back(4'hF);
        exp_q.push_back(4'hB);
        send_frame(8'h2A, 1'b1);
        send_frame(8'h23, 1'b1);
        send_frame(8'h62, 1'b1);
        wait_clks(20);
        check("b2b_kv_cycles", 32'(kv_n), 32'd4);
        check("b2b_errors", 32'(ce_n + fe_n), 32'd0);
        check("b2b_err_led", 32'(bus.err_led), 32'd0);
        check_keys("b2b");

        // 'Z' is not a keypad character
        send_frame(8'h5A, 1'b1);
        wait_clks(20);
        check("z_char_err", 32'(ce_n), 32'd1);
        check("z_kv_cycles", 32'(kv_n), 32'd4);
        check("z_key_code_held", 32'(bus.key_code), 32'hB);
        check("z_err_led", 32'(bus.err_led), 32'd1);
        check_keys("z");

        // bad stop bit then a held-low line
        kv0 = kv_n; ce0 = ce_n;
        send_frame(8'h31, 1'b0);
        bus.rx = 1'b0;
        wait_clks(30 * CPB);
        check("brk_frame_err", 32'(fe_n), 32'd1);
        check("brk_state", 32'(bus.state_dbg), 32'd4);
        check("brk_rx_led", 32'(bus.rx_led), 32'd1);
        bus.rx = 1'b1;
        wait_clks(10);
        check("brk_idle_state", 32'(bus.state_dbg), 32'd0);
        check("brk_idle_led", 32'(bus.rx_led), 32'd0);
        check("brk_no_frames", 32'((kv_n - kv0) + (ce_n - ce0)), 32'd0);
        check("brk_frame_err_once", 32'(fe_n), 32'd1);
        check("brk_key_code_held", 32'(bus.key_code), 32'hB);

        // 3-clock low glitch while idle
        kv0 = kv_n; ce0 = ce_n; fe0 = fe_n;
        led_hi = 0;
        bus.rx = 1'b0;
        wait_clks(3);
        bus.rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.rx_led) led_hi++;
            wait_clks(1);
        end
        check("glitch_led_window", 32'(led_hi >= 1 && led_hi <= 6), 32'd1);
        check("glitch_led_off", 32'(bus.rx_led), 32'd0);
        check("glitch_no_pulses", 32'((kv_n - kv0) + (ce_n - ce0) + (fe_n - fe0)), 32'd0);

        // reset during data bit 4 of '9'
        kv0 = kv_n; ce0 = ce_n; fe0 = fe_n;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(((8'h39 >> i) & 8'h01) != 8'h00);
        bus.rx = 1'b1;
        wait_clks(5);
        rst = 1'b1;
        wait_clks(2);
        check("mid_rst_key_code", 32'(bus.key_code), 32'h0);
        check("mid_rst_err_led", 32'(bus.err_led), 32'd0);
        check("mid_rst_rx_led", 32'(bus.rx_led), 32'd0);
        check("mid_rst_state", 32'(bus.state_dbg), 32'd0);
        rst = 1'b0;
        wait_clks(20);
        check("mid_rst_no_pulses", 32'((kv_n - kv0) + (ce_n - ce0) + (fe_n - fe0)), 32'd0);
        exp_q.push_back(4'h4);
        send_frame(8'h34, 1'b1);
        wait_clks(20);
        check("post_rst_kv_cycles", 32'(kv_n - kv0), 32'd1);
        check("post_rst_key_code", 32'(bus.key_code), 32'h4);
        check_keys("post_rst");

        check("one_hot_pulses", 32'(multi_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_keypad.md
Name: uart_rx_keypad

Overview:
UART receiver that deserialises 8N1 frames from the host and maps ASCII keypad characters back to 4-bit keypad codes. It is the receive-side counterpart of the keypad-to-ASCII UART transmitter top. Its outputs drive the display/LED logic on the board, and it provides status pulses and LEDs for frame and character errors.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate
CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE, clocks per bit; integer division, must be >= 4

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  UART serial line, idle high, asynchronous to clk
key_code  output  4  last successfully decoded keypad code (held)
key_valid  output  1  one-cycle pulse when key_code is updated
char_err  output  1  one-cycle pulse: frame good but character not in keypad set
frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_led  output  1  high while a frame is in progress (states other than IDLE)
err_led  output  1  sticky error indicator, cleared only by rst

Behaviour:
- Reset values: key_code=4'h0, key_valid=0, char_err=0, frame_err=0, rx_led=0, err_led=0, FSM in IDLE, synchroniser flops=1, bit counter=0, shift register=0.
- rx passes through a 2-flop synchroniser; all FSM decisions use the synchronised value rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: clk counter held at 0. On rx_s==0, go to START.
- START: count to CLKS_PER_BIT/2-1. At that mid-bit point, if rx_s==0, clear the counter and go to DATA. If rx_s==1 (glitch), return to IDLE with no outputs.
- DATA: sample rx_s every CLKS_PER_BIT clocks (mid-bit) into the shift register, LSB first. After 8 samples, go to STOP.
- STOP: sample rx_s after CLKS_PER_BIT clocks.
  - If rx_s==1, decode the byte and return to IDLE.
  - If rx_s==0, pulse frame_err, set err_led, discard the byte, and go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line does not produce repeated frames.
- Decode (applied on a good stop bit only):
  - 0x30..0x39 -> 0..9
  - 0x41..0x44 and 0x61..0x64 -> A..D
  - 0x2A -> E
  - 0x23 -> F
- Outputs after decode:
  - Valid character: key_code is updated and key_valid pulses high in the cycle after the stop-bit sample.
  - Any other byte: char_err pulses in that same cycle, err_led is set, and key_code and key_valid are unchanged.
- At most one of key_valid, char_err, frame_err is high in any cycle. All three are registered.
- Back-to-back frames: IDLE is re-entered at the stop-bit mid-point, so a start edge arriving half a bit later is accepted.
- rst asserted mid-frame: immediate return to reset values. The partial byte is lost and no pulse is generated.
- Counters are sized to $clog2(CLKS_PER_BIT). The bit index is 3 bits and does not wrap beyond 8 samples.

Test Plan:
(Bench uses CLK_FREQ=1_000_000, BAUD_RATE=100_000, giving CLKS_PER_BIT=10.)
- Send 0x37 ('7') as 8N1 -> key_code=4'h7; key_valid high exactly 1 cycle, about 95 clks after the start edge; char_err=0, frame_err=0.
- Send 0x2A, 0x23, 0x62 back-to-back with no idle gap -> three key_valid pulses with key_code = E, F, B in order.
- Send 0x5A ('Z') -> char_err single pulse, err_led=1, key_code keeps its previous value, no key_valid.
- Send 0x31 with stop bit forced low, then hold rx low for 30 bit times, then release -> one frame_err pulse only, no spurious frames, FSM returns to IDLE after rx goes high.
- Drive a 3-clk low glitch on rx in IDLE -> no output pulses, rx_led drops back to 0 within 6 clks.
- Assert rst during data bit 4 of 0x39, release, then send 0x34 -> all outputs return to reset values, then key_code=4'h4 with a single key_valid.
